// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Recovers the digits shown on a multiplexed, active-low 7-segment display by
// snooping its segment bus and digit-select lines. Both buses are synchronized
// and debounced. A stable single-digit sample is decoded into a shadow frame.
// Once all eight positions have been captured, the frame is offered on a
// valid/ready output.
//
// Parameters
//   STABLE_CYC  consecutive identical synchronized samples needed before a
//               sample is accepted (1..255)
//
// Ports
//   sys_clk    in   1   clock, rising edge
//   sys_rst_n  in   1   asynchronous active-low reset
//   dig        in   8   active-low segments {dp,g,f,e,d,c,b,a}, async
//   bit_ctrl   in   8   active-low digit select, bit n low = position n, async
//   digits     out  32  frame result, nibble n = position n
//   dp_out     out  8   decimal point per position, 1 = lit
//   out_valid  out  1   digits/dp_out hold an unconsumed frame
//   out_ready  in   1   consumer takes the frame when high with out_valid
//   err        out  1   sticky: unknown segment code or multi-select accepted
//   ovf        out  1   sticky: completed frame dropped while output was held
//
// Build option
//   SEG_SCAN_DP_DECODE_EN  when defined, decimal points are captured per
//                          position. Otherwise dp_out is tied to zero and no
//                          dp storage exists.
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  dig,
    input  logic [7:0]  bit_ctrl,
    output logic [31:0] digits,
    output logic [7:0]  dp_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [7:0] dig_meta, dig_sync;
    logic [7:0] ctl_meta, ctl_sync;

    // NOTE: non-blocking assignments make every flop take its pre-edge value.
    // With blocking assignments the two synchronizer stages would collapse
    // into one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dig_meta <= 8'hFF;
            dig_sync <= 8'hFF;
            ctl_meta <= 8'hFF;
            ctl_sync <= 8'hFF;
        end else begin
            dig_meta <= dig;
            dig_sync <= dig_meta;
            ctl_meta <= bit_ctrl;
            ctl_sync <= ctl_meta;
        end
    end

    // ------------------------------------------------------ stability FSM
    // The prev register holds the last sample. It is frozen during S_LATCH,
    // so it equals the sample being accepted. S_WAIT therefore compares
    // against the accepted value. A change that lands during the latch cycle
    // is still detected, and an unchanged bus is never accepted twice.
    logic [7:0] dig_prev, ctl_prev;
    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [8:0] cnt_inc;
    logic       changed;

    assign changed = (dig_sync != dig_prev) || (ctl_sync != ctl_prev);
    assign cnt_inc = {1'b0, cnt} + 9'd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dig_prev <= 8'hFF;
            ctl_prev <= 8'hFF;
        end else if (state != S_LATCH) begin
            dig_prev <= dig_sync;
            ctl_prev <= ctl_sync;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_WAIT;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first. A path that
        // leaves one unassigned would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_WAIT: begin
                if (changed) begin
                    cnt_next   = 8'd1;
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (changed) begin
                    cnt_next = 8'd1;
                end else begin
                    cnt_next = cnt_inc[7:0];
                    if (cnt_inc >= 9'(STABLE_CYC)) state_next = S_LATCH;
                end
            end
            S_LATCH: state_next = S_WAIT;
            default: state_next = S_WAIT;
        endcase
    end

    // ----------------------------------------------------------- decoding
    function automatic logic [3:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_seg = 4'd0;
            7'h79:   decode_seg = 4'd1;
            7'h24:   decode_seg = 4'd2;
            7'h30:   decode_seg = 4'd3;
            7'h19:   decode_seg = 4'd4;
            7'h12:   decode_seg = 4'd5;
            7'h02:   decode_seg = 4'd6;
            7'h78:   decode_seg = 4'd7;
            7'h00:   decode_seg = 4'd8;
            7'h10:   decode_seg = 4'd9;
            7'h7F:   decode_seg = 4'hF;
            default: decode_seg = 4'hE;
        endcase
    endfunction

    logic            accept;
    logic [7:0]      sel;
    logic            one_sel, multi_sel;
    logic [2:0]      pos;
    logic [3:0]      nib;
    logic [7:0][3:0] shadow, shadow_upd;
    logic [7:0]      seen, seen_upd;
    logic            frame_done, can_load;

    assign accept    = (state == S_LATCH);
    assign sel       = ~ctl_prev;
    // A nonzero value with a single set bit clears when ANDed with itself minus one.
    assign one_sel   = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    assign multi_sel = (sel != 8'h00) && !one_sel;
    assign nib       = decode_seg(dig_prev[6:0]);

    always_comb begin
        pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) pos = 3'(i);
        end
        shadow_upd      = shadow;
        shadow_upd[pos] = nib;
        seen_upd        = seen | (8'd1 << pos);
    end

    assign frame_done = accept && one_sel && (seen_upd == 8'hFF);
    assign can_load   = !out_valid || out_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: the shadow frame is register storage, not a RAM, so it is
            // reset explicitly. Positions of a post-reset frame then start
            // blank (F) rather than undefined.
            shadow    <= {8{4'hF}};
            seen      <= 8'h00;
            digits    <= 32'hFFFF_FFFF;
            out_valid <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (accept && multi_sel) err <= 1'b1;
            if (accept && one_sel) begin
                shadow <= shadow_upd;
                if (nib == 4'hE) err <= 1'b1;
                // Completing a frame starts the next one with nothing seen.
                seen <= (seen_upd == 8'hFF) ? 8'h00 : seen_upd;
            end
            if (frame_done && can_load) begin
                digits    <= shadow_upd;
                out_valid <= 1'b1;
            end else begin
                if (frame_done) ovf <= 1'b1;
                if (out_valid && out_ready) out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------ decimal points
`ifdef SEG_SCAN_DP_DECODE_EN
    logic [7:0] dp_shadow, dp_shadow_upd, dp_q;

    always_comb begin
        dp_shadow_upd      = dp_shadow;
        dp_shadow_upd[pos] = ~dig_prev[7];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dp_shadow <= 8'h00;
            dp_q      <= 8'h00;
        end else begin
            if (accept && one_sel)     dp_shadow <= dp_shadow_upd;
            if (frame_done && can_load) dp_q     <= dp_shadow_upd;
        end
    end

    assign dp_out = dp_q;
`else
    assign dp_out = 8'h00;
`endif

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- STABLE_CYC, 4, consecutive identical synchronized samples required to accept a digit (legal range 1..255).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- sys_clk, in, 1, single clock; all logic rising-edge.
- sys_rst_n, in, 1, asynchronous active-low reset.
- dig, in, 8, active-low segment bus {dp,g,f,e,d,c,b,a}, asynchronous to sys_clk.
- bit_ctrl, in, 8, active-low digit select; bit n low selects position n; asynchronous to sys_clk.
- digits, out, 32, frame result; nibble n (bits 4n+3:4n) is position n's value.
- dp_out, out, 8, decimal-point state per position; 1 = lit.
- out_valid, out, 1, digits/dp_out hold an unconsumed frame.
- out_ready, in, 1, consumer accepts the frame when high with out_valid.
- err, out, 1, sticky: an unknown segment code or multi-select bit_ctrl was accepted.
- ovf, out, 1, sticky: a completed frame was dropped because the output was still held.

Function
REQ-003 The block SHALL pass dig and bit_ctrl through a 2-flop synchronizer; all further logic SHALL use only the synchronized values.
REQ-004 The block SHALL run a 3-state FSM:
- S_WAIT: on any sample differing from the previous sample, reload the stability counter to 1 and go to S_COUNT.
- S_COUNT: increment the counter while the sample is unchanged; on a change, reload to 1 and stay; when the counter reaches STABLE_CYC, go to S_LATCH.
- S_LATCH: accept the sample for exactly one cycle, then go to S_WAIT. The same sample SHALL NOT be accepted again until the inputs change.
REQ-005 An accepted sample with bit_ctrl == 8'hFF SHALL be ignored.
REQ-006 An accepted sample with more than one bit_ctrl bit low SHALL be ignored and SHALL set err.
REQ-007 An accepted sample with exactly one bit_ctrl bit low (position p) SHALL decode dig[6:0] as follows:
- 40,79,24,30,19,12,02,78,00,10 (hex) decode to 0..9.
- 7F (blank) decodes to 4'hF.
- Any other code decodes to 4'hE and sets err.
- The result is written to shadow nibble p, and seen[p] is set.
REQ-008 When seen reaches 8'hFF, a frame is complete; at the same edge seen SHALL clear.
REQ-009 On frame completion, if out_valid is 0, or out_valid and out_ready are both 1 in that cycle, then shadow SHALL be copied to digits/dp_out and out_valid SHALL be 1 from the next cycle.
REQ-010 On frame completion with out_valid=1 and out_ready=0, the frame SHALL be discarded, digits SHALL stay unchanged, and ovf SHALL be set.
REQ-011 out_valid SHALL clear on the cycle after an out_valid & out_ready handshake with no simultaneous frame completion.
REQ-012 digits and dp_out SHALL be stable while out_valid is high and out_ready is low.
REQ-013 A re-accepted position p before the frame completes SHALL overwrite shadow nibble p (last value wins) and SHALL NOT complete the frame.
REQ-014 Worst-case latency from the final position's inputs becoming stable to out_valid being high SHALL be 2 (sync) + STABLE_CYC + 2 cycles.

Reset
REQ-015 While sys_rst_n is low, the following SHALL hold:
- digits = 32'hFFFF_FFFF.
- dp_out = 0, out_valid = 0, err = 0, ovf = 0.
- seen = 0, shadow = all 4'hF.
- Synchronizer flops = 8'hFF.
- FSM = S_WAIT, counter = 0.
REQ-016 Reset asserted mid-frame or mid-handshake SHALL discard all partial state; after release, the first frame SHALL require all 8 positions anew.
REQ-017 err and ovf SHALL clear only on reset.

Configuration
REQ-018 With macro SEG_SCAN_DP_DECODE_EN defined, dp_out[p] SHALL capture ~dig[7] at acceptance of position p, and follow the same frame/hold rules as digits.
REQ-019 Without SEG_SCAN_DP_DECODE_EN, dp_out SHALL be tied to 8'h00, and no dp storage flops SHALL be synthesized.
REQ-020 In both configurations, dig[7] SHALL never affect digit decode or err.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Scan positions 0..7 with codes 40,79,24,30,19,12,02,78, each held 10 cycles, out_ready=1 -> one out_valid pulse, digits=32'h7654_3210, err=0.
- Hold position 3 code 24 for STABLE_CYC-1 cycles, then change to position 4 -> position 3 is not written; seen[3]=0.
- Complete frame A with out_ready=0, then complete frame B -> digits stays at frame A, ovf=1; raise out_ready -> out_valid drops next cycle.
- Accept bit_ctrl=8'hF3 (positions 2 and 3 both low), then code 7'h55 on position 0 -> err=1; the 7'h55 nibble reads E in the next frame.
- Assert sys_rst_n low after 5 positions are accepted -> all outputs at reset values; the next frame needs all 8 positions.
- With SEG_SCAN_DP_DECODE_EN defined, dig=8'h40 on position 1 (dp lit) -> dp_out[1]=1, nibble 1 = 0; without the macro -> dp_out=0.
